// File: rtl/secuenciador_serial_izq_der.sv
// Bit-serial MSB-first unsigned A > B comparator with valid/ready handshakes.
// Optional SECUENCIADOR_EARLY_EXIT_EN: finish as soon as the decision is made.
module secuenciador_serial_izq_der #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         Zout,
  output logic         Eq,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  logic          p;
  logic          q;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [CW-1:0] count;

  logic          ai;
  logic          bi;
  logic          p_n;
  logic          q_n;
  logic [CW-1:0] count_n;
  logic          fin;

  assign ai      = sa[N-1];
  assign bi      = sb[N-1];
  assign p_n     = p | (~q & ai & ~bi);
  assign q_n     = q | (~p & ~ai & bi);
  assign count_n = count - CW'(1);

`ifdef SECUENCIADOR_EARLY_EXIT_EN
  assign fin = (count_n == '0) | p_n | q_n;
`else
  assign fin = (count_n == '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      p         <= 1'b0;
      q         <= 1'b0;
      sa        <= '0;
      sb        <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      Zout      <= 1'b0;
      Eq        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sa       <= A;
            sb       <= B;
            p        <= 1'b0;
            q        <= 1'b0;
            count    <= CW'(N);
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          p     <= p_n;
          q     <= q_n;
          sa    <= {sa[N-2:0], 1'b0};
          sb    <= {sb[N-2:0], 1'b0};
          count <= count_n;
          if (fin) begin
            Zout      <= p_n;
            Eq        <= ~p_n & ~q_n;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_serial_izq_der.sv
// Directed bench for secuenciador_serial_izq_der (N=3).
// Build with SECUENCIADOR_EARLY_EXIT_EN to expect early-exit latencies.
module tb_secuenciador_serial_izq_der;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic         Zout;
  logic         Eq;
  logic         busy;

  int checks = 0;
  int failures = 0;

  secuenciador_serial_izq_der #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Zout     (Zout),
    .Eq       (Eq),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         z;
    logic         e;
    int           lat_full;
    int           lat_early;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input int full, input int early);
`ifdef SECUENCIADOR_EARLY_EXIT_EN
    return early;
`else
    return full;
`endif
  endfunction

  // edges after the accept edge until out_valid is seen
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("wait_ready", int'(in_ready), 1);
  endtask

  task automatic run_op(input vec_t v, input string name);
    int lat;
    wait_ready();
    A = v.a;
    B = v.b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    chk({name, "_lat"}, lat, exp_lat(v.lat_full, v.lat_early));
    chk({name, "_z"}, int'(Zout), int'(v.z));
    chk({name, "_eq"}, int'(Eq), int'(v.e));
    tick();
    chk({name, "_rdy"}, int'(in_ready), 1);
    chk({name, "_ov"}, int'(out_valid), 0);
  endtask

  initial begin
    int lat;
    vec_t t;
    vecs[0]  = '{3'd5, 3'd3, 1'b1, 1'b0, 3, 1};
    vecs[1]  = '{3'd3, 3'd3, 1'b0, 1'b1, 3, 3};
    vecs[2]  = '{3'd2, 3'd3, 1'b0, 1'b0, 3, 3};
    vecs[3]  = '{3'd6, 3'd1, 1'b1, 1'b0, 3, 1};
    vecs[4]  = '{3'd7, 3'd0, 1'b1, 1'b0, 3, 1};
    vecs[5]  = '{3'd0, 3'd7, 1'b0, 1'b0, 3, 1};
    vecs[6]  = '{3'd1, 3'd0, 1'b1, 1'b0, 3, 3};
    vecs[7]  = '{3'd4, 3'd5, 1'b0, 1'b0, 3, 3};
    vecs[8]  = '{3'd3, 3'd4, 1'b0, 1'b0, 3, 1};
    vecs[9]  = '{3'd6, 3'd7, 1'b0, 1'b0, 3, 3};
    vecs[10] = '{3'd2, 3'd1, 1'b1, 1'b0, 3, 2};
    vecs[11] = '{3'd0, 3'd0, 1'b0, 1'b1, 3, 3};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_zout", int'(Zout), 0);
    chk("rst_eq", int'(Eq), 0);
    chk("rst_busy", int'(busy), 0);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i], $sformatf("vec%0d", i));

    // in_valid held while busy: new A/B must be ignored
    A = 3'd2;
    B = 3'd3;
    in_valid = 1'b1;
    tick();
    chk("hold_in_ready", int'(in_ready), 0);
    chk("hold_busy", int'(busy), 1);
    A = 3'd7;
    B = 3'd0;
    wait_out(lat);
    in_valid = 1'b0;
    chk("hold_lat", lat, 3);
    chk("hold_z", int'(Zout), 0);
    chk("hold_eq", int'(Eq), 0);
    tick();

    // consumer stalls five cycles
    out_ready = 1'b0;
    wait_ready();
    A = 3'd6;
    B = 3'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    chk("stall_lat", lat, exp_lat(3, 1));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ov", int'(out_valid), 1);
      chk("stall_z", int'(Zout), 1);
      chk("stall_eq", int'(Eq), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_rdy", int'(in_ready), 1);
    chk("stall_ov_low", int'(out_valid), 0);

    // reset in the second SHIFT cycle
    A = 3'd5;
    B = 3'd4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_rdy", int'(in_ready), 1);
    chk("mid_rst_ov", int'(out_valid), 0);
    chk("mid_rst_z", int'(Zout), 0);
    chk("mid_rst_eq", int'(Eq), 0);
    chk("mid_rst_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_quiet", int'(out_valid), 0);
    end
    t = '{3'd7, 3'd0, 1'b1, 1'b0, 3, 1};
    run_op(t, "after_rst");

    // back-to-back with in_valid held
    A = 3'd4;
    B = 3'd4;
    in_valid = 1'b1;
    tick();
    A = 3'd0;
    B = 3'd7;
    wait_out(lat);
    chk("b2b1_lat", lat, 3);
    chk("b2b1_eq", int'(Eq), 1);
    chk("b2b1_z", int'(Zout), 0);
    tick();
    chk("b2b_idle_rdy", int'(in_ready), 1);
    tick();
    chk("b2b2_accept", int'(busy), 1);
    chk("b2b2_rdy", int'(in_ready), 0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("b2b2_lat", lat, exp_lat(3, 1));
    chk("b2b2_z", int'(Zout), 0);
    chk("b2b2_eq", int'(Eq), 0);
    tick();
    chk("b2b2_done", int'(in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
